// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core. It steps each instruction through
// FETCH/DECODE/EXEC/MEM/MDU/WB and drives the datapath enables for each step.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   instr            instruction register contents (valid from DECODE on)
//   mem_ready        memory access completes this cycle
//   branch_taken     datapath comparator result, used in EXEC
//   mdu_done         MDU result valid, used only in MDU
//   ir_write, pc_write, pc_src, jalr           fetch / PC control
//   mem_req, mem_we, mem_size, mem_unsigned    memory port control
//   alu_op, alu_in1, alu_in2                   ALU control and operand selects
//   wb_sel, reg_write                          register write-back control
//   mdu_start                                  one-cycle MDU launch
//   instr_done                                 retire pulse
//   illegal                                    sticky illegal-instruction flag
//   state                                      current FSM state (debug)
//
// Handshakes: mem_req stays high until mem_ready is seen high; the access
// completes on the clock edge where both are high. mdu_start is a single-cycle
// pulse, after which the FSM waits in MDU for mdu_done; the result is taken on
// the edge where mdu_done is high.
module multicycle_control #(
   parameter bit ENABLE_M     = 1'b1,
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        branch_taken,
   input  logic        mdu_done,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        jalr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_size,
   output logic        mem_unsigned,
   output logic [3:0]  alu_op,
   output logic        alu_in1,
   output logic [1:0]  alu_in2,
   output logic [1:0]  wb_sel,
   output logic        reg_write,
   output logic        mdu_start,
   output logic        instr_done,
   output logic        illegal,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_MDU    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
      C_LUI, C_AUIPC, C_MUL, C_ILL
   } cls_t;

   state_t     state_q, state_d;
   cls_t       cls_q, cls_d, cls_dec;
   logic       illegal_q, illegal_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;
   logic       unused_instr_bits;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   // Register specifiers other than rd belong to the datapath.
   assign unused_instr_bits = ^instr[24:15];

   // Opcode classification; only consumed while in DECODE.
   always_comb begin
      cls_dec = C_ILL;
      case (opcode)
         7'b0110011: begin
            if (funct7 == 7'b0000001) cls_dec = ENABLE_M ? C_MUL : C_ILL;
            else                      cls_dec = C_R;
         end
         7'b0010011: cls_dec = C_I;
         7'b0000011: cls_dec = C_LOAD;
         7'b0100011: cls_dec = C_STORE;
         7'b1100011: cls_dec = C_BRANCH;
         7'b1101111: cls_dec = C_JAL;
         7'b1100111: cls_dec = C_JALR;
         7'b0110111: cls_dec = C_LUI;
         7'b0010111: cls_dec = C_AUIPC;
         default:    cls_dec = C_ILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         cls_q     <= C_ILL;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      cls_d     = (state_q == ST_DECODE) ? cls_dec : cls_q;
      case (state_q)
         ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            if (cls_dec == C_ILL) state_d = ILLEGAL_TRAP ? ST_TRAP : ST_FETCH;
            else                  state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (cls_q)
               C_BRANCH:       state_d = ST_FETCH;
               C_LOAD, C_STORE: state_d = ST_MEM;
               C_MUL:          state_d = ST_MDU;
               default:        state_d = ST_WB;
            endcase
         end
         ST_MEM: if (mem_ready) state_d = (cls_q == C_LOAD) ? ST_WB : ST_FETCH;
         ST_MDU: if (mdu_done) state_d = ST_WB;
         ST_WB:   state_d = ST_FETCH;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_FETCH;
      endcase
      illegal_d = illegal_q | (state_d == ST_TRAP);
   end

   // ALU controls from the latched class; driven in both EXEC and WB so the
   // ALU result is still available while the register file is written.
   logic [3:0] alu_op_c;
   logic       alu_in1_c;
   logic [1:0] alu_in2_c;

   always_comb begin
      alu_op_c  = 4'b0000;
      alu_in1_c = 1'b0;
      alu_in2_c = 2'b00;
      case (cls_q)
         C_R: alu_op_c = {funct7[5], funct3};
         C_I: begin
            // Only the shifts use funct7[5] (SRLI vs SRAI).
            alu_op_c  = (funct3 == 3'b001 || funct3 == 3'b101) ? {funct7[5], funct3}
                                                               : {1'b0, funct3};
            alu_in2_c = 2'b01;
         end
         C_LOAD, C_STORE: alu_in2_c = 2'b01;
         C_BRANCH: alu_op_c = 4'b1000;
         C_LUI: begin
            alu_op_c  = 4'b1111;
            alu_in2_c = 2'b01;
         end
         C_AUIPC: begin
            alu_in1_c = 1'b1;
            alu_in2_c = 2'b01;
         end
         C_JAL, C_JALR: begin
            alu_in1_c = 1'b1;
            alu_in2_c = 2'b10;
         end
         default: ;
      endcase
   end

   // Output decode. Gated by rst_n so that an asserted reset drops every
   // request at once, without waiting for an edge or for mem_ready.
   always_comb begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      jalr         = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_size     = 2'b10;
      mem_unsigned = 1'b0;
      alu_op       = 4'b0000;
      alu_in1      = 1'b0;
      alu_in2      = 2'b00;
      wb_sel       = 2'b00;
      reg_write    = 1'b0;
      mdu_start    = 1'b0;
      instr_done   = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ready;
            end
            ST_DECODE: begin
               if (cls_dec == C_ILL && !ILLEGAL_TRAP) begin
                  pc_write   = 1'b1;
                  instr_done = 1'b1;
               end
            end
            ST_EXEC: begin
               alu_op  = alu_op_c;
               alu_in1 = alu_in1_c;
               alu_in2 = alu_in2_c;
               if (cls_q == C_BRANCH) begin
                  pc_write   = 1'b1;
                  pc_src     = branch_taken;
                  instr_done = 1'b1;
               end
               mdu_start = (cls_q == C_MUL);
            end
            ST_MEM: begin
               mem_req = 1'b1;
               if (cls_q == C_STORE) begin
                  mem_we     = 1'b1;
                  mem_size   = funct3[1:0];
                  pc_write   = mem_ready;
                  instr_done = mem_ready;
               end else begin
                  {mem_unsigned, mem_size} = funct3;
               end
            end
            ST_WB: begin
               alu_op     = alu_op_c;
               alu_in1    = alu_in1_c;
               alu_in2    = alu_in2_c;
               reg_write  = (rd != 5'd0);
               wb_sel     = (cls_q == C_LOAD) ? 2'b01 : (cls_q == C_MUL) ? 2'b10 : 2'b00;
               pc_write   = 1'b1;
               pc_src     = (cls_q == C_JAL) || (cls_q == C_JALR);
               jalr       = (cls_q == C_JALR);
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign illegal = illegal_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;

   localparam int N_DUT = 3;   // 0: default, 1: ENABLE_M=0, 2: ILLEGAL_TRAP=0

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N_DUT-1:0] rst_n_v;
   logic [31:0]      instr;
   logic             mem_ready, branch_taken, mdu_done;

   logic [N_DUT-1:0]      ir_write_w, pc_write_w, pc_src_w, jalr_w, mem_req_w, mem_we_w;
   logic [N_DUT-1:0]      mem_unsigned_w, alu_in1_w, reg_write_w, mdu_start_w;
   logic [N_DUT-1:0]      instr_done_w, illegal_w;
   logic [N_DUT-1:0][1:0] mem_size_w, alu_in2_w, wb_sel_w;
   logic [N_DUT-1:0][3:0] alu_op_w;
   logic [N_DUT-1:0][2:0] state_w;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      multicycle_control #(.ENABLE_M(g != 1), .ILLEGAL_TRAP(g != 2)) dut (
         .clk(clk), .rst_n(rst_n_v[g]), .instr(instr), .mem_ready(mem_ready),
         .branch_taken(branch_taken), .mdu_done(mdu_done),
         .ir_write(ir_write_w[g]), .pc_write(pc_write_w[g]), .pc_src(pc_src_w[g]),
         .jalr(jalr_w[g]), .mem_req(mem_req_w[g]), .mem_we(mem_we_w[g]),
         .mem_size(mem_size_w[g]), .mem_unsigned(mem_unsigned_w[g]),
         .alu_op(alu_op_w[g]), .alu_in1(alu_in1_w[g]), .alu_in2(alu_in2_w[g]),
         .wb_sel(wb_sel_w[g]), .reg_write(reg_write_w[g]), .mdu_start(mdu_start_w[g]),
         .instr_done(instr_done_w[g]), .illegal(illegal_w[g]), .state(state_w[g])
      );
   end

   typedef struct packed {
      logic       ir_write, pc_write, pc_src, jalr, mem_req, mem_we;
      logic [1:0] mem_size;
      logic       mem_unsigned;
      logic [3:0] alu_op;
      logic       alu_in1;
      logic [1:0] alu_in2;
      logic [1:0] wb_sel;
      logic       reg_write, mdu_start, instr_done, illegal;
      logic [2:0] state;
   } ctl_t;

   logic [1:0] sel;   // which instance the current test observes
   ctl_t       o;
   always_comb begin
      o.ir_write     = ir_write_w[sel];
      o.pc_write     = pc_write_w[sel];
      o.pc_src       = pc_src_w[sel];
      o.jalr         = jalr_w[sel];
      o.mem_req      = mem_req_w[sel];
      o.mem_we       = mem_we_w[sel];
      o.mem_size     = mem_size_w[sel];
      o.mem_unsigned = mem_unsigned_w[sel];
      o.alu_op       = alu_op_w[sel];
      o.alu_in1      = alu_in1_w[sel];
      o.alu_in2      = alu_in2_w[sel];
      o.wb_sel       = wb_sel_w[sel];
      o.reg_write    = reg_write_w[sel];
      o.mdu_start    = mdu_start_w[sel];
      o.instr_done   = instr_done_w[sel];
      o.illegal      = illegal_w[sel];
      o.state        = state_w[sel];
   end

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5;
   localparam int K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_MUL = 9, K_ILL = 10;

   typedef struct {
      bit         trap;
      int         cycles;       // retire: cycles incl. done cycle; trap: cycle index of TRAP
      bit         has_exec;
      logic [3:0] alu_op;
      logic       alu_in1;
      logic [1:0] alu_in2;
      logic       mem_we;
      logic [1:0] mem_size;
      logic       mem_unsigned;
      int         n_reg_write;
      int         n_mdu_start;
      logic [1:0] wb_sel;
      logic       pc_src;
      logic       jalr;
   } exp_t;

   function automatic int classify(input logic [31:0] ins, input bit en_m);
      case (ins[6:0])
         7'h33:   return (ins[31:25] == 7'h01) ? (en_m ? K_MUL : K_ILL) : K_R;
         7'h13:   return K_I;
         7'h03:   return K_LOAD;
         7'h23:   return K_STORE;
         7'h63:   return K_BR;
         7'h6F:   return K_JAL;
         7'h67:   return K_JALR;
         7'h37:   return K_LUI;
         7'h17:   return K_AUIPC;
         default: return K_ILL;
      endcase
   endfunction

   // Expected behaviour of one instruction. fw/mw = wait cycles before
   // mem_ready in FETCH/MEM, ml = MDU cycles from start to done.
   function automatic exp_t model(input logic [31:0] ins, input bit en_m, input bit trap_ill,
                                  input int fw, input int mw, input int ml, input logic bt);
      exp_t e;
      int   k;
      bit   writes;
      logic [2:0] f3;
      k  = classify(ins, en_m);
      f3 = ins[14:12];
      writes = (k == K_R || k == K_I || k == K_LOAD || k == K_JAL || k == K_JALR ||
                k == K_LUI || k == K_AUIPC || k == K_MUL);
      e.trap     = (k == K_ILL) && trap_ill;
      e.has_exec = (k != K_ILL);
      case (k)
         K_ILL:   e.cycles = fw + 2;
         K_BR:    e.cycles = fw + 3;
         K_STORE: e.cycles = fw + 4 + mw;
         K_LOAD:  e.cycles = fw + 5 + mw;
         K_MUL:   e.cycles = fw + 4 + ml;
         default: e.cycles = fw + 4;
      endcase
      if (k == K_R)                           e.alu_op = {ins[30], f3};
      else if (k == K_I)                      e.alu_op = (f3 == 3'd1 || f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
      else if (k == K_BR)                     e.alu_op = 4'd8;
      else if (k == K_LUI)                    e.alu_op = 4'd15;
      else                                    e.alu_op = 4'd0;
      e.alu_in1 = (k == K_JAL || k == K_JALR || k == K_AUIPC);
      if (k == K_I || k == K_LOAD || k == K_STORE || k == K_LUI || k == K_AUIPC) e.alu_in2 = 2'b01;
      else if (k == K_JAL || k == K_JALR)                                         e.alu_in2 = 2'b10;
      else                                                                        e.alu_in2 = 2'b00;
      e.mem_we       = (k == K_STORE);
      e.mem_size     = f3[1:0];
      e.mem_unsigned = (k == K_LOAD) ? f3[2] : 1'b0;
      e.n_reg_write  = (writes && ins[11:7] != 5'd0) ? 1 : 0;
      e.n_mdu_start  = (k == K_MUL) ? 1 : 0;
      e.wb_sel       = (k == K_LOAD) ? 2'b01 : (k == K_MUL) ? 2'b10 : 2'b00;
      e.pc_src       = (k == K_BR) ? bt : (k == K_JAL || k == K_JALR);
      e.jalr         = (k == K_JALR);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr(input bit allow_ill);
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, allow_ill ? 10 : 9))
         0: begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 2))
               0:       w[31:25] = 7'h00;
               1:       w[31:25] = 7'h20;
               default: w[31:25] = 7'h01;
            endcase
         end
         1: w[6:0] = 7'h13;
         2: w[6:0] = 7'h03;
         3: w[6:0] = 7'h23;
         4: w[6:0] = 7'h63;
         5: w[6:0] = 7'h6F;
         6: w[6:0] = 7'h67;
         7: w[6:0] = 7'h37;
         8: w[6:0] = 7'h17;
         9: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
         default: w[6:0] = 7'($urandom);
      endcase
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   // All tasks start and end just after a falling edge.
   task automatic reset_dut(input int idx);
      rst_n_v[idx] = 1'b0;
      mem_ready    = 1'b1;
      repeat (2) @(negedge clk);
      rst_n_v[idx] = 1'b1;
   endtask

   task automatic run_one(input string name, input logic [31:0] ins, input int fw,
                          input int mw, input int ml, input logic bt);
      exp_t       e;
      int         fk, mk, dk, cyc, done_at, trap_at;
      int         n_done, n_ir, n_pcw, n_rw, n_ms, bad_mem, bad_misc, bad_wb, bad_trap;
      bit         seen_exec;
      logic [2:0] st;
      logic [3:0] x_op;
      logic       x_in1, r_src, r_jalr;
      logic [1:0] x_in2, r_wb;
      e = model(ins, sel != 2'd1, sel != 2'd2, fw, mw, ml, bt);
      fk = 0; mk = 0; dk = 0; cyc = 0; done_at = -1; trap_at = -1;
      n_done = 0; n_ir = 0; n_pcw = 0; n_rw = 0; n_ms = 0;
      bad_mem = 0; bad_misc = 0; bad_wb = 0; bad_trap = 0; seen_exec = 0;
      x_op = 'x; x_in1 = 'x; x_in2 = 'x; r_wb = 'x; r_src = 'x; r_jalr = 'x;
      while (cyc < 200 && done_at < 0 && trap_at < 0) begin
         st           = o.state;
         instr        = (st == 3'd1 || st >= 3'd2) ? ins : $urandom;
         mem_ready    = 1'($urandom_range(0, 1));
         mdu_done     = 1'($urandom_range(0, 1));
         branch_taken = 1'($urandom_range(0, 1));
         case (st)
            3'd0: begin fk++; mem_ready = (fk == fw + 1); end
            3'd2: branch_taken = bt;
            3'd3: begin mk++; mem_ready = (mk == mw + 1); end
            3'd4: begin dk++; mdu_done = (dk == ml); end
            default: ;
         endcase
         #1;
         n_done += o.instr_done;
         n_ir   += o.ir_write;
         n_pcw  += o.pc_write;
         n_rw   += o.reg_write;
         n_ms   += o.mdu_start;
         if (o.state == 3'd2 && !seen_exec) begin
            seen_exec = 1; x_op = o.alu_op; x_in1 = o.alu_in1; x_in2 = o.alu_in2;
         end
         if (o.state == 3'd3 &&
             {o.mem_we, o.mem_size, o.mem_unsigned} !== {e.mem_we, e.mem_size, e.mem_unsigned})
            bad_mem++;
         if (o.state == 3'd5 && {o.alu_op, o.alu_in1, o.alu_in2} !== {e.alu_op, e.alu_in1, e.alu_in2})
            bad_wb++;
         if (o.mem_req !== (o.state == 3'd0 || o.state == 3'd3)) bad_misc++;
         if (o.illegal !== (o.state == 3'd6)) bad_misc++;
         if (o.state != 3'd3 && (o.mem_size !== 2'b10 || o.mem_we !== 1'b0)) bad_misc++;
         if (o.instr_done === 1'b1) begin
            done_at = cyc + 1; r_wb = o.wb_sel; r_src = o.pc_src; r_jalr = o.jalr;
         end
         if (o.state == 3'd6) trap_at = cyc;
         cyc++;
         @(negedge clk);
      end
      if (done_at < 0 && trap_at < 0) begin
         errors++;
         $display("FAIL %s timeout: no retire or trap within %0d cycles (instr %h)", name, cyc, ins);
      end
      checks++;
      if ((e.trap ? trap_at : done_at) !== e.cycles) begin
         errors++;
         $display("FAIL %s cycles: got done=%0d trap=%0d want %0d (instr %h)", name, done_at, trap_at, e.cycles, ins);
      end
      checks++;
      if (n_done !== (e.trap ? 0 : 1)) begin
         errors++; $display("FAIL %s instr_done count: got %0d want %0d (instr %h)", name, n_done, e.trap ? 0 : 1, ins);
      end
      checks++;
      if (n_ir !== 1) begin
         errors++; $display("FAIL %s ir_write count: got %0d want 1", name, n_ir);
      end
      checks++;
      if (n_pcw !== (e.trap ? 0 : 1)) begin
         errors++; $display("FAIL %s pc_write count: got %0d want %0d (instr %h)", name, n_pcw, e.trap ? 0 : 1, ins);
      end
      checks++;
      if (n_rw !== e.n_reg_write) begin
         errors++; $display("FAIL %s reg_write count: got %0d want %0d (instr %h)", name, n_rw, e.n_reg_write, ins);
      end
      checks++;
      if (n_ms !== e.n_mdu_start) begin
         errors++; $display("FAIL %s mdu_start count: got %0d want %0d (instr %h)", name, n_ms, e.n_mdu_start, ins);
      end
      checks++;
      if (bad_mem != 0 || bad_misc != 0 || bad_wb != 0) begin
         errors++;
         $display("FAIL %s per-cycle controls: got mem=%0d misc=%0d wb_alu=%0d bad cycles want 0 (instr %h)",
                  name, bad_mem, bad_misc, bad_wb, ins);
      end
      if (e.has_exec) begin
         checks++;
         if ({x_op, x_in1, x_in2} !== {e.alu_op, e.alu_in1, e.alu_in2}) begin
            errors++;
            $display("FAIL %s exec alu: got op=%b in1=%b in2=%b want op=%b in1=%b in2=%b (instr %h)",
                     name, x_op, x_in1, x_in2, e.alu_op, e.alu_in1, e.alu_in2, ins);
         end
      end
      if (!e.trap) begin
         checks++;
         if ({r_wb, r_src, r_jalr} !== {e.wb_sel, e.pc_src, e.jalr}) begin
            errors++;
            $display("FAIL %s retire: got wb_sel=%b pc_src=%b jalr=%b want %b %b %b (instr %h)",
                     name, r_wb, r_src, r_jalr, e.wb_sel, e.pc_src, e.jalr, ins);
         end
      end
      if (trap_at >= 0) begin
         repeat (6) begin
            instr = $urandom; mem_ready = 1'($urandom_range(0, 1));
            mdu_done = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
            #1;
            if (o.state !== 3'd6 || o.illegal !== 1'b1 || o.instr_done || o.ir_write ||
                o.pc_write || o.mem_req || o.reg_write || o.mdu_start)
               bad_trap++;
            @(negedge clk);
         end
         checks++;
         if (bad_trap != 0) begin
            errors++; $display("FAIL %s trap sticky: got %0d bad cycles want 0", name, bad_trap);
         end
      end
      if (trap_at >= 0 || done_at < 0) reset_dut(int'(sel));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      ctl_t r;
      int   bad;
      r = '0;
      r.mem_size = 2'b10;
      sel = 2'd0;
      rst_n_v = '0;
      mem_ready = 1'b1; mdu_done = 1'b0; branch_taken = 1'b0; instr = 32'h0;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         instr = $urandom; mdu_done = 1'($urandom_range(0, 1));
         #1;
         if (o !== r) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL reset_outputs: got %h want %h", o, r);
      end
      @(negedge clk);
      rst_n_v   = '1;
      mem_ready = 1'b0;
      #1;
      checks++;
      if (o.state !== 3'd0 || o.mem_req !== 1'b1 || o.ir_write !== 1'b0) begin
         errors++; $display("FAIL reset_release: got state=%0d mem_req=%b ir_write=%b want 0 1 0",
                            o.state, o.mem_req, o.ir_write);
      end
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (o.state !== 3'd0 || o.mem_req !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL fetch_hold: got %0d cycles out of FETCH want 0", bad);
      end
      @(negedge clk);
   endtask

   task automatic test_directed();
      sel = 2'd0;
      run_one("addi",     32'h00500093, 0, 0, 1, 1'b0);
      run_one("lw_wait3", 32'h0040A103, 0, 3, 1, 1'b0);
      run_one("beq_t",    32'h00208463, 0, 0, 1, 1'b1);
      run_one("beq_nt",   32'h00208463, 0, 0, 1, 1'b0);
      run_one("mul_l6",   32'h022081B3, 0, 0, 6, 1'b0);
      run_one("sb_fw2",   32'h00208023, 2, 1, 1, 1'b0);
      run_one("jalr",     32'h000080E7, 0, 0, 1, 1'b0);
   endtask

   task automatic test_no_m();
      sel = 2'd1;
      reset_dut(1);
      run_one("mul_nom", 32'h022081B3, 0, 0, 6, 1'b0);
      run_one("add_nom", 32'h002081B3, 1, 0, 1, 1'b0);
   endtask

   task automatic test_ill_nop();
      sel = 2'd2;
      reset_dut(2);
      run_one("ill_nop", 32'h0000007F, 0, 0, 1, 1'b0);
      run_one("lui_nt",  32'h123450B7, 0, 0, 1, 1'b0);
   endtask

   task automatic test_reset_mid_mem();
      int i;
      sel = 2'd2;
      instr = 32'h00208023;   // sb x2,0(x1)
      i = 0;
      while (i < 20 && o.state !== 3'd3) begin
         mem_ready = (o.state == 3'd0);
         i++;
         @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      checks++;
      if (o.state !== 3'd3 || o.mem_req !== 1'b1 || o.mem_we !== 1'b1 || o.mem_size !== 2'b00) begin
         errors++; $display("FAIL sb_mem: got state=%0d req=%b we=%b size=%b want 3 1 1 00",
                            o.state, o.mem_req, o.mem_we, o.mem_size);
      end
      @(negedge clk);
      rst_n_v[2] = 1'b0;
      #1;
      checks++;
      if (o.mem_req !== 1'b0 || o.state !== 3'd0 || o.mem_we !== 1'b0 || o.mem_size !== 2'b10) begin
         errors++; $display("FAIL reset_mid_mem: got req=%b state=%0d we=%b size=%b want 0 0 0 10",
                            o.mem_req, o.state, o.mem_we, o.mem_size);
      end
      @(negedge clk);
      rst_n_v[2] = 1'b1;
      run_one("after_rst", 32'h00A00113, 0, 0, 1, 1'b0);
   endtask

   task automatic test_random();
      sel = 2'd0;
      reset_dut(0);
      for (int i = 0; i < 40; i++)
         run_one("rand_a", rand_instr(1'b1), $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(1, 7), 1'($urandom_range(0, 1)));
      sel = 2'd2;
      reset_dut(2);
      for (int i = 0; i < 30; i++)
         run_one("rand_c", rand_instr(1'b1), $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(1, 7), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_back_to_back();
      sel = 2'd0;
      reset_dut(0);
      for (int i = 0; i < 20; i++)
         run_one("b2b", rand_instr(1'b0), 0, 0, 1, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_no_m();
      test_ill_nop();
      test_reset_mid_mem();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I core. It replaces the single-cycle combinational decoder with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/MDU/WB.
- It drives datapath enables per state and handshakes with a variable-latency memory port.
- When M-extension support is enabled, it handshakes with an iterative multiply/divide unit (MDU).
- It sits between the instruction register, the datapath muxes, the memory interface and the MDU.

Parameters:
- ENABLE_M, 1: 1 decodes M ops (opcode 0110011, funct7=0000001) and routes them to the MDU; 0 treats them as illegal.
- ILLEGAL_TRAP, 1: 1 sends unknown opcodes to TRAP; 0 retires them as NOPs (PC+4, no write).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction register contents; stable from the cycle after ir_write.
- mem_ready  in  1  memory access completes this cycle.
- branch_taken  in  1  datapath comparator result; valid in EXEC.
- mdu_done  in  1  MDU result valid.
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = target.
- jalr  out  1  target base = rs1, with bit 0 cleared; else PC.
- mem_req  out  1  memory request.
- mem_we  out  1  store.
- mem_size  out  2  00 = byte, 01 = half, 10 = word.
- mem_unsigned  out  1  zero-extend load.
- alu_op  out  4  ALU operation.
- alu_in1  out  1  0 = rs1, 1 = PC.
- alu_in2  out  2  00 = rs2, 01 = imm, 10 = 4.
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = MDU.
- reg_write  out  1  register file write.
- mdu_start  out  1  one-cycle MDU launch.
- instr_done  out  1  retire pulse.
- illegal  out  1  sticky illegal-instruction flag.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, MDU=4, WB=5, TRAP=6.

Behaviour:
- Reset: state=FETCH. All outputs are 0 except mem_size=10. The illegal flag is cleared. Reset mid-access drops mem_req combinationally; the FSM does not wait for mem_ready.
- Control outputs are decoded from the current state and the registered instruction class latched in DECODE. There are no glitch-free guarantees beyond that; the datapath samples on clk.
- FETCH: mem_req=1, mem_we=0, mem_size=10. Hold until mem_ready. On mem_ready: ir_write=1, go to DECODE. The FSM stays in FETCH indefinitely while mem_ready=0.
- DECODE: classify the opcode into R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MUL or ILL and latch the class.
  - ILL with ILLEGAL_TRAP=1: go to TRAP.
  - ILL with ILLEGAL_TRAP=0: pc_write=1, pc_src=0, instr_done=1, go to FETCH.
  - Otherwise go to EXEC.
- EXEC alu_op encoding:
  - R: {funct7[5],funct3}.
  - I: {funct7[5],funct3} for funct3=001/101, otherwise {0,funct3}.
  - BRANCH: 1000.
  - LUI: 1111.
  - All other classes: 0000.
- EXEC operand selects:
  - alu_in2=01 for I, LOAD, STORE, LUI and AUIPC.
  - JAL and JALR: alu_in1=1, alu_in2=10.
  - AUIPC: alu_in1=1.
- EXEC next state:
  - BRANCH: pc_write=1, pc_src=branch_taken, instr_done=1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - MUL: mdu_start=1 for exactly one cycle, go to MDU.
  - All others: go to WB.
- MEM:
  - mem_req=1, mem_we=1 for STORE.
  - LOAD: {mem_unsigned,mem_size}=funct3.
  - STORE: mem_size=funct3[1:0], mem_unsigned=0.
  - Hold until mem_ready. Then LOAD goes to WB. STORE asserts pc_write=1, pc_src=0, instr_done=1 and goes to FETCH.
- MDU: wait for mdu_done, which is sampled only in MDU, so minimum latency is 1 cycle after mdu_start. Then go to WB. mdu_start is never re-asserted while waiting.
- WB:
  - reg_write=1 unless rd (instr[11:7])==0.
  - wb_sel: 01 for LOAD, 10 for MUL, 00 otherwise.
  - pc_write=1, pc_src=1 for JAL/JALR (jalr=1 for JALR), else 0.
  - instr_done=1, go to FETCH.
- TRAP: illegal=1 and stays set. All enables are 0. The FSM leaves TRAP only on reset.
- Latency (zero-wait memory/MDU):
  - ALU op, JAL, JALR: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - MUL: 5 cycles + (MDU latency - 1).
- instr_done pulses exactly once per retired instruction and never in TRAP.

Test Plan:
- Reset held low with mem_ready=1, then released → state=0 and mem_req=1 on the first cycle. addi x1,x0,5 (0x00500093) retires in 4 cycles: WB cycle has reg_write=1, wb_sel=00, alu_op=0000, alu_in2=01.
- lw x2,4(x1) (0x0040A103) with mem_ready delayed 3 cycles in MEM → mem_size=10 and mem_unsigned=0 held throughout. WB cycle has wb_sel=01. instr_done occurs 8 cycles after FETCH start.
- beq (0x00208463) with branch_taken=1 → 3 cycles, alu_op=1000, pc_src=1 on the EXEC cycle. Repeat with branch_taken=0 → pc_src=0.
- mul x3,x1,x2 (0x022081B3), ENABLE_M=1, mdu_done 6 cycles after start → mdu_start high for exactly 1 cycle, WB has wb_sel=10. With ENABLE_M=0 → TRAP, illegal=1 sticky.
- Opcode 0x0000007F with ILLEGAL_TRAP=0 → retires in 2 cycles with pc_write=1, reg_write=0. Then assert rst_n=0 mid-MEM for sb (0x00208023) → mem_req drops immediately and state=0.
